// File: rtl/trigger_measure_pkg.sv
// ---------------------------------------------------------------------------
// trigger_measure_pkg
//
// Purpose:
//   Shared timing definitions for the trigger path blocks (delay generator
//   and trigger_measure). Holds the measurement FSM state encoding and the
//   default counter/result width so both sides agree on one width.
//
// Contents:
//   TIMING_WIDTH   default width of counters, results and timeout
//   tm_state_e     measurement FSM states (idle, delay, length, done)
// ---------------------------------------------------------------------------
package trigger_measure_pkg;

    localparam int unsigned TIMING_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StLength = 2'd2,
        StDone   = 2'd3
    } tm_state_e;

endpackage

// File: rtl/trigger_measure_edge_detect.sv
// ---------------------------------------------------------------------------
// trigger_measure_edge_detect
//
// Purpose:
//   Rising-edge detector: registers the previous sample of a level input and
//   flags the cycle where the input is 1 and the previous sample was 0.
//   The previous-sample register has no reset on purpose: it keeps tracking
//   the input while the rest of the design is held in reset, so a level that
//   is already high when reset is released does not look like a fresh edge.
//
// Ports:
//   i_clk   clock
//   i_sig   level input to watch
//   o_rise  1 in the cycle where i_sig is 1 and was 0 one cycle earlier
// ---------------------------------------------------------------------------
module trigger_measure_edge_detect (
    input  logic i_clk,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/trigger_measure.sv
// ---------------------------------------------------------------------------
// trigger_measure
//
// Purpose:
//   Receive-side counterpart of the trigger delay generator. Measures the
//   delay from a reference trigger's rising edge to the rising edge of the
//   returned pulse, and the returned pulse's length, both in clock cycles.
//   One result is held on a valid/ready interface until it is accepted.
//
// Ports:
//   ipClk      clock
//   Reset      synchronous, active-high reset
//   ipEnable   arms measurement; low aborts a measurement in progress
//   ipTimeout  abort threshold (cycles) for the delay and length phases;
//              0 disables the timeout
//   ipTrigger  reference trigger level (rising edge starts a measurement)
//   ipPulse    returned pulse level (rising edge starts the length phase)
//   opDelay    measured delay: t1 - t0 - 1 (t0 trigger edge, t1 pulse edge)
//   opLength   measured pulse length in cycles high
//   opTimeout  result was cut short by the timeout; qualified by opValid
//   opValid    result available
//   ipReady    consumer accepts the result when high with opValid
// ---------------------------------------------------------------------------
module trigger_measure
    import trigger_measure_pkg::*;
#(
    parameter int unsigned WIDTH = TIMING_WIDTH
) (
    input  logic             ipClk,
    input  logic             Reset,
    input  logic             ipEnable,
    input  logic [WIDTH-1:0] ipTimeout,
    input  logic             ipTrigger,
    input  logic             ipPulse,
    output logic [WIDTH-1:0] opDelay,
    output logic [WIDTH-1:0] opLength,
    output logic             opTimeout,
    output logic             opValid,
    input  logic             ipReady
);

    // -----------------------------------------------------------------------
    // Edge detection on both inputs
    // -----------------------------------------------------------------------
    logic w_trig_edge;
    logic w_pulse_edge;

    trigger_measure_edge_detect u_trig_edge (
        .i_clk  (ipClk),
        .i_sig  (ipTrigger),
        .o_rise (w_trig_edge)
    );

    trigger_measure_edge_detect u_pulse_edge (
        .i_clk  (ipClk),
        .i_sig  (ipPulse),
        .o_rise (w_pulse_edge)
    );

    // -----------------------------------------------------------------------
    // State and result registers
    // -----------------------------------------------------------------------
    tm_state_e        r_state;
    logic [WIDTH-1:0] r_delay_cnt;
    logic [WIDTH-1:0] r_len_cnt;
    logic [WIDTH-1:0] r_delay;
    logic [WIDTH-1:0] r_length;
    logic             r_timeout;
    logic             r_valid;

    // -----------------------------------------------------------------------
    // Counter helpers
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] w_delay_inc;
    logic [WIDTH-1:0] w_len_inc;
    logic             w_timeout_en;
    logic             w_delay_expired;
    logic             w_len_expired;

    // Saturating increments: a counter parked at all-ones stays there.
    assign w_delay_inc = (&r_delay_cnt) ? r_delay_cnt : r_delay_cnt + WIDTH'(1);
    assign w_len_inc   = (&r_len_cnt)   ? r_len_cnt   : r_len_cnt + WIDTH'(1);

    // >= rather than == so a threshold lowered mid-measurement still fires.
    assign w_timeout_en    = |ipTimeout;
    assign w_delay_expired = w_timeout_en && (r_delay_cnt >= ipTimeout);
    assign w_len_expired   = w_timeout_en && (r_len_cnt >= ipTimeout);

    // -----------------------------------------------------------------------
    // Measurement FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_delay_cnt <= '0;
            r_len_cnt   <= '0;
            r_delay     <= '0;
            r_length    <= '0;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (ipEnable && w_trig_edge) begin
                        r_delay_cnt <= '0;
                        r_state     <= StDelay;
                    end
                end

                // Counting trigger-to-pulse cycles. A pulse edge coincident
                // with the trigger edge is seen in StIdle and so never lands
                // here; a pulse already high on entry needs a fresh edge.
                StDelay: begin
                    if (!ipEnable) begin
                        r_state <= StIdle;
                    end else if (w_pulse_edge) begin
                        r_delay   <= r_delay_cnt;
                        r_len_cnt <= WIDTH'(1);
                        r_state   <= StLength;
                    end else if (w_delay_expired) begin
                        r_delay   <= ipTimeout;
                        r_length  <= '0;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= StDone;
                    end else begin
                        r_delay_cnt <= w_delay_inc;
                    end
                end

                // Counting cycles high. The pulse-edge cycle already counted
                // as 1, so the count equals the number of cycles high when
                // the first low cycle arrives.
                StLength: begin
                    if (!ipEnable) begin
                        r_state <= StIdle;
                    end else if (!ipPulse) begin
                        r_length  <= r_len_cnt;
                        r_timeout <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= StDone;
                    end else if (w_len_expired) begin
                        r_length  <= ipTimeout;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= StDone;
                    end else begin
                        r_len_cnt <= w_len_inc;
                    end
                end

                // Hold the result until accepted. Triggers here, including
                // in the handshake cycle itself, are dropped (no queueing),
                // and ipEnable is not looked at.
                StDone: begin
                    if (ipReady) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign opDelay   = r_delay;
    assign opLength  = r_length;
    assign opTimeout = r_timeout;
    assign opValid   = r_valid;

endmodule

// File: tb/tb_trigger_measure.sv
module tb_trigger_measure;

    logic        ipClk = 1'b0;
    logic        Reset;
    logic        ipEnable;
    logic [31:0] ipTimeout;
    logic        ipTrigger;
    logic        ipPulse;
    logic        ipReady;
    logic [31:0] opDelay;
    logic [31:0] opLength;
    logic        opTimeout;
    logic        opValid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference trigger delay generator: output high for gen_l cycles,
    // starting gen_d + 1 cycles after the trigger-edge cycle.
    logic gen_en   = 1'b0;
    logic man_pulse = 1'b0;
    int   gen_d    = 1;
    int   gen_l    = 1;
    logic gen_prev = 1'b0;
    logic gen_busy = 1'b0;
    int   gen_t    = 0;
    logic gen_pulse;

    always @(posedge ipClk) begin
        gen_prev <= ipTrigger;
        if (ipTrigger && !gen_prev) begin
            gen_t    <= 1;
            gen_busy <= 1'b1;
        end else if (gen_busy) begin
            if (gen_t >= gen_d + gen_l) gen_busy <= 1'b0;
            else gen_t <= gen_t + 1;
        end
    end

    assign gen_pulse = gen_busy && (gen_t >= gen_d + 1) && (gen_t <= gen_d + gen_l);
    assign ipPulse   = gen_en ? gen_pulse : man_pulse;

    always #5 ipClk = ~ipClk;

    trigger_measure #(
        .WIDTH (32)
    ) dut (
        .ipClk     (ipClk),
        .Reset     (Reset),
        .ipEnable  (ipEnable),
        .ipTimeout (ipTimeout),
        .ipTrigger (ipTrigger),
        .ipPulse   (ipPulse),
        .opDelay   (opDelay),
        .opLength  (opLength),
        .opTimeout (opTimeout),
        .opValid   (opValid),
        .ipReady   (ipReady)
    );

    task automatic tick();
        @(posedge ipClk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        int n = 0;
        while (opValid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        got = (opValid === 1'b1);
    endtask

    task automatic test_reset();
        Reset = 1'b1; ipEnable = 1'b1; ipTimeout = '0; ipTrigger = 1'b0;
        ipReady = 1'b0; man_pulse = 1'b0; gen_en = 1'b0;
        repeat (3) tick();
        ipTrigger = 1'b1;
        tick();
        checks++;
        if ({opValid, opTimeout, opDelay, opLength} !== 66'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b t=%0b d=%0d l=%0d exp all 0",
                     opValid, opTimeout, opDelay, opLength);
        end
        // Trigger stays high across release: must not start a measurement.
        Reset = 1'b0;
        man_pulse = 1'b1;
        repeat (3) tick();
        man_pulse = 1'b0;
        repeat (3) tick();
        ipTrigger = 1'b0;
        tick();
        checks++;
        if (opValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_no_edge: got valid=%0b exp 0", opValid);
        end
    endtask

    task automatic test_loopback();
        bit got;
        int c;
        bit stable = 1'b1;
        gen_en = 1'b1; gen_d = 10; gen_l = 5;
        c = cyc;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(100, got);
        checks++;
        if (!got || (cyc - c) != 17) begin
            failures++;
            $display("FAIL loopback_latency: got valid=%0b after %0d cycles exp 1 after 17",
                     got, cyc - c);
        end
        checks++;
        if (opDelay !== 32'd10 || opLength !== 32'd5 || opTimeout !== 1'b0) begin
            failures++;
            $display("FAIL loopback_result: got d=%0d l=%0d t=%0b exp d=10 l=5 t=0",
                     opDelay, opLength, opTimeout);
        end
        repeat (5) begin
            tick();
            if (opValid !== 1'b1 || opDelay !== 32'd10 || opLength !== 32'd5) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL loopback_hold: got stable=%0b exp 1", stable);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        checks++;
        if (opValid !== 1'b0 || opDelay !== 32'd10) begin
            failures++;
            $display("FAIL loopback_handshake: got v=%0b d=%0d exp v=0 d=10", opValid, opDelay);
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        bit got;
        int c;
        bit stable = 1'b1;
        bit seen = 1'b0;
        gen_en = 1'b1; gen_d = 3; gen_l = 2;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(50, got);
        checks++;
        if (!got || opDelay !== 32'd3 || opLength !== 32'd2) begin
            failures++;
            $display("FAIL bp_first: got v=%0b d=%0d l=%0d exp v=1 d=3 l=2",
                     got, opDelay, opLength);
        end
        // 20 cycles without ready, trigger edges at cycles 0, 6 and 12.
        for (int k = 0; k < 20; k++) begin
            ipTrigger = (k % 6 < 2) && (k < 18);
            tick();
            if ({opValid, opTimeout, opDelay, opLength} !== {1'b1, 1'b0, 32'd3, 32'd2})
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_stable: got stable=%0b exp 1", stable);
        end
        // Trigger edge in the handshake cycle must be dropped.
        ipReady = 1'b1; ipTrigger = 1'b1;
        tick();
        ipReady = 1'b0; ipTrigger = 1'b0;
        checks++;
        if (opValid !== 1'b0) begin
            failures++;
            $display("FAIL bp_handshake: got valid=%0b exp 0", opValid);
        end
        repeat (15) begin
            tick();
            if (opValid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL bp_single_result: got extra valid=%0b exp 0", seen);
        end
        c = cyc;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(50, got);
        checks++;
        if (!got || (cyc - c) != 7 || opDelay !== 32'd3 || opLength !== 32'd2) begin
            failures++;
            $display("FAIL bp_next: got v=%0b lat=%0d d=%0d l=%0d exp v=1 lat=7 d=3 l=2",
                     got, cyc - c, opDelay, opLength);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        bit got;
        int c;
        gen_en = 1'b0; man_pulse = 1'b0; ipTimeout = 32'd100;
        c = cyc;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(300, got);
        checks++;
        if (!got || (cyc - c) != 102) begin
            failures++;
            $display("FAIL to_delay_latency: got v=%0b lat=%0d exp v=1 lat=102", got, cyc - c);
        end
        checks++;
        if (opTimeout !== 1'b1 || opDelay !== 32'd100 || opLength !== 32'd0) begin
            failures++;
            $display("FAIL to_delay_result: got t=%0b d=%0d l=%0d exp t=1 d=100 l=0",
                     opTimeout, opDelay, opLength);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        tick();
        // Pulse stuck high for 500 cycles after D=4.
        gen_en = 1'b1; gen_d = 4; gen_l = 500;
        c = cyc;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(300, got);
        checks++;
        if (!got || (cyc - c) != 106) begin
            failures++;
            $display("FAIL to_len_latency: got v=%0b lat=%0d exp v=1 lat=106", got, cyc - c);
        end
        checks++;
        if (opTimeout !== 1'b1 || opDelay !== 32'd4 || opLength !== 32'd100) begin
            failures++;
            $display("FAIL to_len_result: got t=%0b d=%0d l=%0d exp t=1 d=4 l=100",
                     opTimeout, opDelay, opLength);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        repeat (410) tick();
        ipTimeout = '0;
        gen_en = 1'b0;
        tick();
    endtask

    task automatic test_boundaries();
        int lat = -1;
        // Pulse already high at the trigger edge, low at +3, high at +8..+9.
        gen_en = 1'b0; man_pulse = 1'b1; ipTrigger = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 14; k++) begin
            ipTrigger = (k == 0);
            man_pulse = (k < 3) || (k == 8) || (k == 9);
            tick();
            if (opValid === 1'b1 && lat < 0) lat = k + 1;
        end
        checks++;
        if (lat != 11 || opDelay !== 32'd7 || opLength !== 32'd2 || opTimeout !== 1'b0) begin
            failures++;
            $display("FAIL bnd_high_at_entry: got lat=%0d d=%0d l=%0d t=%0b exp 11 7 2 0",
                     lat, opDelay, opLength, opTimeout);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        tick();
        // Pulse edge coincident with trigger edge, then real edge at +6 for 3.
        lat = -1;
        for (int k = 0; k < 14; k++) begin
            ipTrigger = (k == 0);
            man_pulse = (k < 2) || (k >= 6 && k <= 8);
            tick();
            if (opValid === 1'b1 && lat < 0) lat = k + 1;
        end
        checks++;
        if (lat != 10 || opDelay !== 32'd5 || opLength !== 32'd3 || opTimeout !== 1'b0) begin
            failures++;
            $display("FAIL bnd_coincident: got lat=%0d d=%0d l=%0d t=%0b exp 10 5 3 0",
                     lat, opDelay, opLength, opTimeout);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bit got;
        int c;
        bit seen = 1'b0;
        gen_en = 1'b0; man_pulse = 1'b0;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        repeat (4) tick();
        ipEnable = 1'b0;
        tick();
        ipEnable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            man_pulse = (k >= 3 && k < 6);
            tick();
            if (opValid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_result: got valid seen=%0b exp 0", seen);
        end
        gen_en = 1'b1; gen_d = 2; gen_l = 1;
        c = cyc;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(50, got);
        checks++;
        if (!got || (cyc - c) != 5 || opDelay !== 32'd2 || opLength !== 32'd1) begin
            failures++;
            $display("FAIL abort_next: got v=%0b lat=%0d d=%0d l=%0d exp v=1 lat=5 d=2 l=1",
                     got, cyc - c, opDelay, opLength);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bit got;
        int c;
        bit seen = 1'b0;
        gen_en = 1'b1; gen_d = 2; gen_l = 10;
        ipTrigger = 1'b1;
        repeat (6) tick();
        checks++;
        if (opDelay !== 32'd2 || opValid !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_delay: got d=%0d v=%0b exp d=2 v=0", opDelay, opValid);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({opValid, opTimeout, opDelay, opLength} !== 66'd0) begin
            failures++;
            $display("FAIL rst_in_length: got v=%0b t=%0b d=%0d l=%0d exp all 0",
                     opValid, opTimeout, opDelay, opLength);
        end
        Reset = 1'b0;
        repeat (20) begin
            tick();
            if (opValid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_no_spurious: got valid seen=%0b exp 0", seen);
        end
        ipTrigger = 1'b0;
        tick();
        gen_l = 3;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(50, got);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (!got || {opValid, opTimeout, opDelay, opLength} !== 66'd0) begin
            failures++;
            $display("FAIL rst_pending: got had_valid=%0b v=%0b d=%0d l=%0d exp 1 0 0 0",
                     got, opValid, opDelay, opLength);
        end
        repeat (3) tick();
        c = cyc;
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
        wait_valid(50, got);
        checks++;
        if (!got || (cyc - c) != 7 || opDelay !== 32'd2 || opLength !== 32'd3) begin
            failures++;
            $display("FAIL rst_after: got v=%0b lat=%0d d=%0d l=%0d exp v=1 lat=7 d=2 l=3",
                     got, cyc - c, opDelay, opLength);
        end
        ipReady = 1'b1;
        tick();
        ipReady = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_backpressure();
        test_timeout();
        test_boundaries();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
